// File: rtl/bp_pkg.sv
// Shared types and constants for the gselect predictor and its branch update queue.
package bp_pkg;
  localparam int PC_W    = 32;
  localparam int PC_INCR = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } bp_entry_t;
endpackage

// File: rtl/buq_fifo.sv
// In-order circular store of in-flight predicted branches with a flush-to-head squash.
module buq_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  bp_entry_t  wdata,
  input  logic       pop,
  input  logic       flush,
  output bp_entry_t  head,
  output logic       head_vld,
  output logic [AW:0] count,
  output logic       full,
  output logic       empty
);
  logic [AW:0]      wr_ptr, rd_ptr, rd_nxt;
  logic [DEPTH-1:0] vld, vld_nxt;
  bp_entry_t        mem [DEPTH];

  assign rd_nxt   = rd_ptr + (AW+1)'(pop);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_vld = vld[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A flush drops everything younger than the popped head, so valid bits all clear.
  always_comb begin
    vld_nxt = vld;
    if (pop) vld_nxt[rd_ptr[AW-1:0]] = 1'b0;
    if (flush) vld_nxt = '0;
    else if (push) vld_nxt[wr_ptr[AW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      vld    <= vld_nxt;
      if (flush)     wr_ptr <= rd_nxt;
      else if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/branch_update_queue.sv
// Tracks predicted branches in flight, trains the predictor on resolve and redirects on mispredict.
// Optional BUQ_STATS_EN adds saturating branch / mispredict counters.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = bp_pkg::PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_target,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic [PC_W-1:0]          resolve_target,
  output logic                     update,
  output logic [PC_W-1:0]          branchPC,
  output logic [PC_W-1:0]          resultPC,
  output logic                     taken,
  output logic                     redirect,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_sticky
`ifdef BUQ_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispredicts
`endif
);
  bp_entry_t wdata, head;
  logic      head_vld, accept, mismatch, flush, push;

  assign wdata    = '{pc: pred_pc, pred_taken: pred_taken, pred_target: pred_target};
  assign accept   = resolve_valid && !empty && head_vld;
  assign mismatch = accept && ((resolve_taken != head.pred_taken) ||
                               (resolve_target != head.pred_target));
  assign flush    = mismatch;
  // A slot frees on a correct resolve, so a push into a full queue is legal then.
  // On a mispredict the same-cycle push is wrong-path and silently dropped.
  assign push     = pred_valid && (!full || accept) && !flush;

  buq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    (wdata),
    .pop      (accept),
    .flush    (flush),
    .head     (head),
    .head_vld (head_vld),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update      <= 1'b0;
      redirect    <= 1'b0;
      taken       <= 1'b0;
      branchPC    <= '0;
      resultPC    <= '0;
      redirect_pc <= '0;
      err_sticky  <= 1'b0;
    end else begin
      update   <= accept;
      redirect <= mismatch;
      if (accept) begin
        branchPC    <= head.pc;
        resultPC    <= resolve_target;
        taken       <= resolve_taken;
        redirect_pc <= resolve_target;
      end
      if ((pred_valid && full && !accept) || (resolve_valid && empty))
        err_sticky <= 1'b1;
    end
  end

`ifdef BUQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept && stat_branches != 32'hFFFF_FFFF)      stat_branches    <= stat_branches + 32'd1;
      if (mismatch && stat_mispredicts != 32'hFFFF_FFFF) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue at DEPTH=4, PC_W=32.
module tb_branch_update_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pred_valid = 1'b0, pred_taken = 1'b0;
  logic [31:0] pred_pc = '0, pred_target = '0;
  logic        resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        update, taken, redirect, full, empty, err_sticky;
  logic [31:0] branchPC, resultPC, redirect_pc;
  logic [2:0]  count;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_update_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .update(update), .branchPC(branchPC), .resultPC(resultPC), .taken(taken),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .full(full), .empty(empty), .count(count), .err_sticky(err_sticky)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tg;
    step();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tg);
    resolve_valid = 1'b1; resolve_taken = tk; resolve_target = tg;
    step();
    resolve_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_update got %b want 0", update); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got %b want 0", redirect); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err_sticky); end
    total++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0)
      begin bad++; $display("FAIL reset_occ got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
    total++; if (branchPC !== 32'h0 || resultPC !== 32'h0 || redirect_pc !== 32'h0)
      begin bad++; $display("FAIL reset_pcs got %h %h %h want 0", branchPC, resultPC, redirect_pc); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    push(32'h100, 1'b1, 32'h200);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got %0d want 1", count); end
    resolve(1'b1, 32'h200);
    total++; if (update !== 1'b1 || redirect !== 1'b0)
      begin bad++; $display("FAIL basic_strobe got upd=%b redir=%b want 1/0", update, redirect); end
    total++; if (branchPC !== 32'h100 || resultPC !== 32'h200 || taken !== 1'b1)
      begin bad++; $display("FAIL basic_data got %h %h %b want 100 200 1", branchPC, resultPC, taken); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty got %b want 1", empty); end
    step();
    total++; if (update !== 1'b0 || branchPC !== 32'h100)
      begin bad++; $display("FAIL basic_hold got upd=%b pc=%h want 0 100", update, branchPC); end
  endtask

  task automatic test_mispredict();
    push(32'h100, 1'b0, 32'h104);
    push(32'h140, 1'b0, 32'h144);
    push(32'h180, 1'b0, 32'h184);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL mis_count3 got %0d want 3", count); end
    resolve(1'b1, 32'h300);
    total++; if (update !== 1'b1 || redirect !== 1'b1 || redirect_pc !== 32'h300 || branchPC !== 32'h100)
      begin bad++; $display("FAIL mis_redirect got upd=%b redir=%b rpc=%h bpc=%h want 1 1 300 100", update, redirect, redirect_pc, branchPC); end
    total++; if (count !== 3'd0 || empty !== 1'b1 || err_sticky !== 1'b0)
      begin bad++; $display("FAIL mis_flush got count=%0d empty=%b err=%b want 0 1 0", count, empty, err_sticky); end
    resolve(1'b0, 32'h0);
    total++; if (update !== 1'b0 || redirect !== 1'b0 || err_sticky !== 1'b1)
      begin bad++; $display("FAIL mis_underflow got upd=%b redir=%b err=%b want 0 0 1", update, redirect, err_sticky); end
  endtask

  task automatic test_overflow_wrap();
    logic [31:0] exp_pc;
    do_reset();
    push(32'h8, 1'b0, 32'hC); resolve(1'b0, 32'hC);
    push(32'h8, 1'b0, 32'hC); resolve(1'b0, 32'hC);
    for (int i = 1; i <= 4; i++) push(32'h10 * i, 1'b0, 32'h10 * i + 32'd4);
    total++; if (full !== 1'b1 || count !== 3'd4 || err_sticky !== 1'b0)
      begin bad++; $display("FAIL ovf_full got full=%b count=%0d err=%b want 1 4 0", full, count, err_sticky); end
    push(32'h50, 1'b0, 32'h54);
    total++; if (count !== 3'd4 || err_sticky !== 1'b1)
      begin bad++; $display("FAIL ovf_drop got count=%0d err=%b want 4 1", count, err_sticky); end
    for (int i = 1; i <= 4; i++) begin
      exp_pc = 32'h10 * i;
      resolve(1'b0, exp_pc + 32'd4);
      total++; if (update !== 1'b1 || redirect !== 1'b0 || branchPC !== exp_pc)
        begin bad++; $display("FAIL ovf_order%0d got upd=%b redir=%b pc=%h want 1 0 %h", i, update, redirect, branchPC, exp_pc); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h400 + 32'h10 * i, 1'b0, 32'h404 + 32'h10 * i);
    pred_valid = 1'b1; pred_pc = 32'h500; pred_taken = 1'b1; pred_target = 32'h600;
    resolve(1'b0, 32'h404);
    pred_valid = 1'b0;
    total++; if (count !== 3'd4 || full !== 1'b1 || err_sticky !== 1'b0 || branchPC !== 32'h400)
      begin bad++; $display("FAIL b2b_full got count=%0d full=%b err=%b pc=%h want 4 1 0 400", count, full, err_sticky, branchPC); end
    for (int i = 1; i < 4; i++) resolve(1'b0, 32'h404 + 32'h10 * i);
    total++; if (branchPC !== 32'h430 || redirect !== 1'b0)
      begin bad++; $display("FAIL b2b_mid got pc=%h redir=%b want 430 0", branchPC, redirect); end
    resolve(1'b1, 32'h600);
    total++; if (update !== 1'b1 || redirect !== 1'b0 || branchPC !== 32'h500 || empty !== 1'b1)
      begin bad++; $display("FAIL b2b_last got upd=%b redir=%b pc=%h empty=%b want 1 0 500 1", update, redirect, branchPC, empty); end
  endtask

  task automatic test_push_mispredict();
    do_reset();
    push(32'h600, 1'b0, 32'h604);
    push(32'h610, 1'b0, 32'h614);
    pred_valid = 1'b1; pred_pc = 32'h620; pred_taken = 1'b0; pred_target = 32'h624;
    resolve(1'b1, 32'h700);
    pred_valid = 1'b0;
    total++; if (count !== 3'd0 || empty !== 1'b1 || redirect !== 1'b1 || redirect_pc !== 32'h700)
      begin bad++; $display("FAIL pmis got count=%0d empty=%b redir=%b rpc=%h want 0 1 1 700", count, empty, redirect, redirect_pc); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL pmis_err got %b want 0", err_sticky); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h900 + 32'h10 * i, 1'b0, 32'h904 + 32'h10 * i);
    resolve(1'b0, 32'h904);
    total++; if (update !== 1'b1 || count !== 3'd3)
      begin bad++; $display("FAIL mrst_pre got upd=%b count=%0d want 1 3", update, count); end
    resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_target = 32'h914;
    rst = 1'b0;
    #1;
    total++; if (count !== 3'd0 || update !== 1'b0 || empty !== 1'b1)
      begin bad++; $display("FAIL mrst_async got count=%0d upd=%b empty=%b want 0 0 1", count, update, empty); end
    step();
    rst = 1'b1;
    step();
    total++; if (update !== 1'b0 || redirect !== 1'b0)
      begin bad++; $display("FAIL mrst_release got upd=%b redir=%b want 0 0", update, redirect); end
    resolve_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mispredict();
    test_overflow_wrap();
    test_back_to_back();
    test_push_mispredict();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
